// File: rtl/fifo_pkg.sv
// Shared constants, types and helpers for the single-clock FIFO family.
// Level/pointer types are sized from the default address width.
package fifo_pkg;

    localparam int DEF_DSIZE = 32;
    localparam int DEF_ASIZE = 5;

    typedef logic [DEF_ASIZE:0] level_t;
    typedef logic [DEF_ASIZE:0] ptr_t;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic bit afull_th_ok(input int asize, input int th);
        return (th >= 1) && (th <= fifo_depth(asize));
    endfunction

    function automatic bit aempty_th_ok(input int asize, input int th);
        return (th >= 0) && (th <= fifo_depth(asize) - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_param_mem.sv
// Simple dual-port RAM: synchronous write, read port either
// registered (standard mode) or combinational (show-ahead mode).
module fifo_sync_param_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE,
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             ren,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem [DEPTH];

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rdata = mem[raddr];
    end else begin : g_reg
        logic [DSIZE-1:0] rd_q;

        // Output register loads only on an accepted read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (ren) begin
                rd_q <= mem[raddr];
            end
        end

        assign rdata = rd_q;
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with show-ahead option, threshold
// flags, fill level and sticky overflow/underflow errors.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DSIZE     = DEF_DSIZE,
    parameter int ASIZE     = DEF_ASIZE,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             err_clr,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   level,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = fifo_depth(ASIZE);

    localparam logic [ASIZE:0] DEPTH_LV = DEPTH[ASIZE:0];
    localparam logic [ASIZE:0] AF_LV    = AFULL_TH[ASIZE:0];
    localparam logic [ASIZE:0] AE_LV    = AEMPTY_TH[ASIZE:0];
    localparam logic [ASIZE:0] ONE      = {{ASIZE{1'b0}}, 1'b1};

    if (ASIZE < 1) begin : g_bad_asize
        $error("fifo_sync_param: ASIZE must be >= 1");
    end

    if (!afull_th_ok(ASIZE, AFULL_TH)) begin : g_bad_afull
        $error("fifo_sync_param: AFULL_TH out of range 1..DEPTH");
    end

    if (!aempty_th_ok(ASIZE, AEMPTY_TH)) begin : g_bad_aempty
        $error("fifo_sync_param: AEMPTY_TH out of range 0..DEPTH-1");
    end

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic           wr_ok;
    logic           rd_ok;

    // Acceptance uses the pre-edge flags, so full rejects a write and
    // empty rejects a read even when the other side is active.
    assign wr_ok = winc && !wfull;
    assign rd_ok = rinc && !rempty;

    assign wfull         = (level == DEPTH_LV);
    assign rempty        = (level == '0);
    assign walmost_full  = (level >= AF_LV);
    assign ralmost_empty = (level <= AE_LV);

    // Pointers and occupancy move only on accepted operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level <= level + ONE;
                2'b01:   level <= level - ONE;
                default: level <= level;
            endcase
        end
    end

    // Sticky errors: a new rejected request wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_sync_param_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .FWFT  (FWFT)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (wr_ok),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (wdata),
        .ren   (rd_ok),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: standard-mode instance checked
// every cycle against a queue model, plus a show-ahead instance.
module tb_fifo_sync_param;

    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] wdata = '0;
    logic        winc = 1'b0;
    logic        rinc = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] rdata;
    logic        wfull, rempty, walmost_full, ralmost_empty;
    logic [5:0]  level;
    logic        overflow, underflow;

    logic [31:0] f_wdata = '0;
    logic        f_winc = 1'b0;
    logic        f_rinc = 1'b0;
    logic        f_err_clr = 1'b0;
    logic [31:0] f_rdata;
    logic        f_wfull, f_rempty, f_walmost_full, f_ralmost_empty;
    logic [5:0]  f_level;
    logic        f_overflow, f_underflow;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .DSIZE(32), .ASIZE(5), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc),
        .rinc(rinc), .err_clr(err_clr), .rdata(rdata), .wfull(wfull),
        .rempty(rempty), .walmost_full(walmost_full),
        .ralmost_empty(ralmost_empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_param #(
        .DSIZE(32), .ASIZE(5), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)
    ) dut_f (
        .clk(clk), .rst_n(rst_n), .wdata(f_wdata), .winc(f_winc),
        .rinc(f_rinc), .err_clr(f_err_clr), .rdata(f_rdata),
        .wfull(f_wfull), .rempty(f_rempty),
        .walmost_full(f_walmost_full), .ralmost_empty(f_ralmost_empty),
        .level(f_level), .overflow(f_overflow), .underflow(f_underflow)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sbq[$];
    logic [31:0] fq[$];
    int          mlevel = 0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [31:0] m_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " level"}, 64'(level), 64'(mlevel));
        chk({tag, " wfull"}, 64'(wfull), 64'(mlevel == DEPTH));
        chk({tag, " rempty"}, 64'(rempty), 64'(mlevel == 0));
        chk({tag, " walmost_full"}, 64'(walmost_full), 64'(mlevel >= AF));
        chk({tag, " ralmost_empty"}, 64'(ralmost_empty), 64'(mlevel <= AE));
        chk({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, " underflow"}, 64'(underflow), 64'(m_unf));
        chk({tag, " rdata"}, 64'(rdata), 64'(m_rdata));
    endtask

    task automatic model_reset();
        sbq.delete();
        mlevel  = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic cycle(input logic w, input logic [31:0] d,
                         input logic r, input logic clr, input string tag);
        bit wacc;
        bit racc;
        wacc = w && (mlevel < DEPTH);
        racc = r && (mlevel > 0);
        if (w && !wacc) m_ovf = 1'b1;
        else if (clr)   m_ovf = 1'b0;
        if (r && !racc) m_unf = 1'b1;
        else if (clr)   m_unf = 1'b0;
        if (racc) m_rdata = sbq.pop_front();
        if (wacc) sbq.push_back(d);
        mlevel = mlevel + (wacc ? 1 : 0) - (racc ? 1 : 0);
        winc    = w;
        wdata   = d;
        rinc    = r;
        err_clr = clr;
        @(posedge clk);
        #1;
        winc    = 1'b0;
        rinc    = 1'b0;
        err_clr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        // Reset, checked while asserted and after release
        model_reset();
        #2;
        check_all("in_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("reset");
        chk("f reset rempty", 64'(f_rempty), 64'd1);
        chk("f reset level", 64'(f_level), 64'd0);

        // Fill to full, then overflow attempt and clear
        for (int i = 1; i <= 32; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, "fill");
        cycle(1'b1, 32'hDEAD, 1'b0, 1'b0, "ovf");
        cycle(1'b0, 32'h0, 1'b0, 1'b1, "ovf_clr");

        // Drain in order, then underflow attempt and clear
        for (int i = 1; i <= 32; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, "drain");
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "unf");
        cycle(1'b0, 32'h0, 1'b0, 1'b1, "unf_clr");

        // Steady-state streaming across pointer wrap
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(100 + i), 1'b0, 1'b0, "half");
        for (int i = 0; i < 100; i++) cycle(1'b1, 32'(200 + i), 1'b1, 1'b0, "stream");
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(400 + i), 1'b0, 1'b0, "refill");
        cycle(1'b1, 32'hBEEF, 1'b1, 1'b0, "full_wr_rd");
        cycle(1'b0, 32'h0, 1'b0, 1'b1, "clr2");
        for (int i = 0; i < 31; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, "drain2");
        cycle(1'b1, 32'h55, 1'b1, 1'b0, "empty_wr_rd");
        cycle(1'b0, 32'h0, 1'b0, 1'b1, "clr3");

        // Show-ahead instance
        f_winc = 1'b1; f_wdata = 32'hA5;
        @(posedge clk); #1;
        f_winc = 1'b0;
        chk("f wr rempty", 64'(f_rempty), 64'd0);
        chk("f wr rdata", 64'(f_rdata), 64'hA5);
        chk("f wr level", 64'(f_level), 64'd1);
        f_rinc = 1'b1;
        @(posedge clk); #1;
        f_rinc = 1'b0;
        chk("f rd rempty", 64'(f_rempty), 64'd1);
        chk("f rd level", 64'(f_level), 64'd0);
        for (int i = 0; i < 3; i++) begin
            f_winc = 1'b1; f_wdata = 32'hB0 + 32'(i);
            fq.push_back(f_wdata);
            @(posedge clk); #1;
        end
        f_winc = 1'b0;
        while (fq.size() > 0) begin
            chk("f head rdata", 64'(f_rdata), 64'(fq.pop_front()));
            f_rinc = 1'b1;
            @(posedge clk); #1;
            f_rinc = 1'b0;
        end
        chk("f drained rempty", 64'(f_rempty), 64'd1);

        // Asynchronous reset mid-stream at level 10
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'(600 + i), 1'b0, 1'b0, "to10");
        chk("pre-rst level", 64'(level), 64'd10);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("f async_rst rempty", 64'(f_rempty), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b1, 32'h77, 1'b0, 1'b0, "post_rst_wr");
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
